chunk_adder: RTL
================

CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK (elaboration error otherwise).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a, b  input  WIDTH  operands, captured on accepted start.
REQ-007 c_in  input  1  carry-in for add mode, captured on accepted start.
REQ-008 sub  input  1  mode, captured on accepted start; 0 = a+b+c_in, 1 = a-b.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 res  output  WIDTH  sum/difference, held until next accepted start.
REQ-012 c_out  output  1  carry out of the MSB chunk.
REQ-013 ovf  output  1  two's-complement signed overflow (see Configuration).

Function
REQ-014 FSM states IDLE, RUN, DONE; NCHUNK = WIDTH/CHUNK.
REQ-015 IDLE: start=1 SHALL capture a, b, sub; effective b = sub ? ~b : b; carry register = sub ? 1 : c_in; chunk index = 0; go RUN.
REQ-016 RUN: each cycle SHALL add chunk[idx] of a, effective b and carry register, write the CHUNK-bit sum into res[idx], update carry register, increment idx.
REQ-017 RUN SHALL go to DONE after the edge that processes idx = NCHUNK-1; no wrap of idx past NCHUNK-1.
REQ-018 DONE lasts exactly one cycle, done=1, then IDLE.
REQ-019 Latency: start sampled at edge k -> done high in the cycle following edge k+NCHUNK; busy high from edge k to edge k+NCHUNK.
REQ-020 start while busy or in DONE SHALL be ignored; no queuing.
REQ-021 Inputs a, b, c_in, sub changing during RUN SHALL not affect the result.
REQ-022 c_out = final carry register; in sub mode c_out=1 means no borrow (a >= b unsigned).
REQ-023 Arithmetic is modulo 2^WIDTH; res bits not yet written during RUN hold undefined-but-stable values and are not observable as valid.
REQ-024 NCHUNK = 1 (CHUNK = WIDTH) SHALL work: one RUN cycle.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, busy=0, done=0, res=0, c_out=0, ovf=0, idx=0, carry register=0, regardless of state.
REQ-026 Reset mid-RUN SHALL abandon the operation; no done pulse follows.
REQ-027 First start SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-028 Macro CHUNK_ADDER_OVF_EN defined: ovf registered on last RUN cycle as carry-into-MSB XOR carry-out-of-MSB, held with res.
REQ-029 Macro undefined: ovf tied to 0, no overflow logic synthesised; all else identical.

Structure
REQ-030 Package chunk_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default WIDTH/CHUNK constants.
REQ-031 One sub-module chunk_slice: combinational CHUNK-bit adder (a, b, cin -> sum, cout, msb carry-in) instantiated once and reused each cycle.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-032 a=0xFFFFFFFF, b=0x1, c_in=0, sub=0 -> done 4 cycles after start, res=0x00000000, c_out=1, ovf=0.
REQ-033 a=0x7FFFFFFF, b=0x1, sub=0 -> res=0x80000000, c_out=0, ovf=1 with OVF_EN, 0 without.
REQ-034 a=5, b=7, sub=1 -> res=0xFFFFFFFE, c_out=0; a=7, b=5, sub=1 -> res=2, c_out=1.
REQ-035 start pulsed again on cycles 1-3 of RUN and in DONE, operands changed -> ignored, result of first operation unchanged, single done pulse.
REQ-036 rst asserted at cycle 2 of RUN -> busy, done, res, c_out drop to 0 immediately; no done; next start completes normally.
REQ-037 WIDTH=16, CHUNK=16: a=0x1234, b=0x4321, c_in=1 -> res=0x5556, done 1 cycle after start.

Source files
------------

// File: rtl/chunk_adder_pkg.sv
// Shared definitions for chunk_adder: FSM state encoding and default operand geometry.
package chunk_adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_adder_slice.sv
// chunk_slice: combinational CHUNK-bit adder with carry out and the carry into its top bit.
module chunk_slice
    import chunk_adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

    assign sum  = total[CHUNK-1:0];
    assign cout = total[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
    assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/chunk_adder.sv
// Multi-cycle adder/subtractor processing CHUNK bits per clock through one reused slice.
// Define CHUNK_ADDER_OVF_EN to register signed overflow; otherwise ovf is tied low.
module chunk_adder
    import chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_geometry_check
        $error("chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry;
    logic             c_out_q;
    logic [IDX_W-1:0] idx;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             msb_cin;
    logic             last;

    chunk_slice #(.CHUNK(CHUNK)) u_slice (
        .a       (a_q[idx*CHUNK +: CHUNK]),
        .b       (b_q[idx*CHUNK +: CHUNK]),
        .cin     (carry),
        .sum     (sum),
        .cout    (cout),
        .msb_cin (msb_cin)
    );

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry   <= 1'b0;
            c_out_q <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b once here and seed the carry.
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : c_in;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_q[idx*CHUNK +: CHUNK] <= sum;
                    carry <= cout;
                    if (last) begin
                        c_out_q <= cout;
                        state   <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign res   = res_q;
    assign c_out = c_out_q;

`ifdef CHUNK_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state == RUN) && last) begin
            ovf_q <= msb_cin ^ cout;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_msb_cin;
    assign unused_msb_cin = msb_cin;
    assign ovf = 1'b0;
`endif

endmodule
